pueo_trig_scheduler: RTL and testbench

Single-clock (aclk) trigger admission controller sitting between the trigger source and the URAM readout/event-buffer path. It gates trigger times by run state, enforces a programmable holdoff, and tracks outstanding events against the event-buffer depth using credits returned by the readout. It issues admitted triggers with sequential event numbers and counts triggers lost to a full buffer.

---
 rtl/pueo_trig_scheduler.sv | 153 +++++++++++++++
 tb/tb_pueo_trig_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pueo_trig_scheduler.sv
// pueo_trig_scheduler
// Trigger admission controller between the trigger source and the URAM
// readout / event-buffer path. Gates triggers by run state, enforces a
// programmable holdoff after each admitted trigger, and tracks outstanding
// events against the buffer depth using credits returned by the readout.
//
// Strobe semantics: every *_valid / *_done / run_* signal here is a one-cycle
// qualifier with no ready/back-pressure. A strobe high in cycle t is consumed
// in cycle t. The associated data (trig_time_*, event_no_o) is meaningful only
// while its strobe is high; the outputs hold their last admitted values.
//
// Ports:
//   aclk_i, aresetn_i  clock, asynchronous active-low reset
//   run_start_i        one-cycle run start request
//   run_stop_i         one-cycle run stop request
//   holdoff_i          idle cycles enforced after each admitted trigger
//   trig_time_i        trigger time, qualified by trig_valid_i
//   trig_valid_i       trigger strobe
//   readout_done_i     one buffer slot returned by the readout
//   trig_time_o        admitted trigger time, qualified by trig_valid_o
//   trig_valid_o       admitted trigger strobe
//   event_no_o         event number of the admitted trigger
//   run_rst_o          one-cycle pulse the cycle after a run starts
//   running_o          high in RUN
//   busy_o             high while any event is outstanding
//   outstanding_o      events admitted but not yet read out
//   dropped_o          triggers rejected for full buffer this run (saturating)
//   state_o            debug view of the FSM state (0 IDLE, 1 RUN, 2 DRAIN)
module pueo_trig_scheduler #(
  parameter int TIME_BITS = 16,
  parameter int NBUF      = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                         aclk_i,
  input  logic                         aresetn_i,
  input  logic                         run_start_i,
  input  logic                         run_stop_i,
  input  logic [15:0]                  holdoff_i,
  input  logic [TIME_BITS-1:0]         trig_time_i,
  input  logic                         trig_valid_i,
  input  logic                         readout_done_i,
  output logic [TIME_BITS-1:0]         trig_time_o,
  output logic                         trig_valid_o,
  output logic [CNT_BITS-1:0]          event_no_o,
  output logic                         run_rst_o,
  output logic                         running_o,
  output logic                         busy_o,
  output logic [$clog2(NBUF+1)-1:0]    outstanding_o,
  output logic [CNT_BITS-1:0]          dropped_o,
  output logic [1:0]                   state_o
);

  localparam int OW = $clog2(NBUF + 1);
  localparam logic [OW-1:0] NBUF_W = OW'(NBUF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] event_cnt_q;
  logic [15:0]         hold_cnt_q;
  logic [OW-1:0]       outstanding_q;

  logic start_go;
  logic trig_ok;
  logic admit;
  logic reject;
  logic credit_ret;

  // State register
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run_start_i && !run_stop_i) state_d = S_RUN;
      S_RUN:   if (run_stop_i) state_d = S_DRAIN;
      // Leaves one cycle after the registered count first reads zero.
      S_DRAIN: if (outstanding_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    running_o  = (state_q == S_RUN);
    state_o    = state_q;
    busy_o     = (outstanding_q != '0);
    start_go   = (state_q == S_IDLE) && run_start_i && !run_stop_i;
    // A stop in the same cycle pre-empts the trigger entirely.
    trig_ok    = (state_q == S_RUN) && !run_stop_i && trig_valid_i &&
                 (hold_cnt_q == '0);
    admit      = trig_ok && (outstanding_q < NBUF_W);
    reject     = trig_ok && (outstanding_q >= NBUF_W);
    // Credits at zero are spurious and ignored rather than wrapping.
    credit_ret = readout_done_i && (outstanding_q != '0);
  end

  // Datapath: counters and registered outputs
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      event_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      outstanding_q <= '0;
      dropped_o     <= '0;
      trig_time_o   <= '0;
      trig_valid_o  <= 1'b0;
      event_no_o    <= '0;
      run_rst_o     <= 1'b0;
    end else begin
      trig_valid_o <= admit;
      run_rst_o    <= start_go;

      if (start_go) begin
        event_cnt_q <= '0;
        dropped_o   <= '0;
        hold_cnt_q  <= '0;
      end else begin
        if (admit) begin
          trig_time_o <= trig_time_i;
          event_no_o  <= event_cnt_q;
          event_cnt_q <= event_cnt_q + CNT_BITS'(1);
          hold_cnt_q  <= holdoff_i;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_q <= hold_cnt_q - 16'd1;
        end

        if (reject && (dropped_o != '1)) begin
          dropped_o <= dropped_o + CNT_BITS'(1);
        end
      end

      if (admit && !credit_ret) begin
        outstanding_q <= outstanding_q + OW'(1);
      end else if (!admit && credit_ret) begin
        outstanding_q <= outstanding_q - OW'(1);
      end
    end
  end

  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_pueo_trig_scheduler.sv
// Directed testbench for pueo_trig_scheduler (TIME_BITS=16, NBUF=4,
// CNT_BITS=16). Inputs change 1 ns after the rising edge; outputs are
// sampled 1 ns after the following rising edge.
module tb_pueo_trig_scheduler;

  logic        aclk;
  logic        aresetn;
  logic        run_start;
  logic        run_stop;
  logic [15:0] holdoff;
  logic [15:0] trig_time;
  logic        trig_valid;
  logic        readout_done;
  logic [15:0] trig_time_o;
  logic        trig_valid_o;
  logic [15:0] event_no_o;
  logic        run_rst_o;
  logic        running_o;
  logic        busy_o;
  logic [2:0]  outstanding_o;
  logic [15:0] dropped_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  pueo_trig_scheduler #(
    .TIME_BITS(16),
    .NBUF(4),
    .CNT_BITS(16)
  ) dut (
    .aclk_i        (aclk),
    .aresetn_i     (aresetn),
    .run_start_i   (run_start),
    .run_stop_i    (run_stop),
    .holdoff_i     (holdoff),
    .trig_time_i   (trig_time),
    .trig_valid_i  (trig_valid),
    .readout_done_i(readout_done),
    .trig_time_o   (trig_time_o),
    .trig_valid_o  (trig_valid_o),
    .event_no_o    (event_no_o),
    .run_rst_o     (run_rst_o),
    .running_o     (running_o),
    .busy_o        (busy_o),
    .outstanding_o (outstanding_o),
    .dropped_o     (dropped_o),
    .state_o       (state_o)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    run_start    = 1'b0;
    run_stop     = 1'b0;
    trig_valid   = 1'b0;
    readout_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(trig_valid_o), 32'd0);
    check({tag, "_time"},  32'(trig_time_o),  32'd0);
    check({tag, "_evno"},  32'(event_no_o),   32'd0);
    check({tag, "_rrst"},  32'(run_rst_o),    32'd0);
    check({tag, "_run"},   32'(running_o),    32'd0);
    check({tag, "_busy"},  32'(busy_o),       32'd0);
    check({tag, "_outs"},  32'(outstanding_o), 32'd0);
    check({tag, "_drop"},  32'(dropped_o),    32'd0);
    check({tag, "_state"}, 32'(state_o),      32'd0);
  endtask

  // Driver tasks: each applies one cycle of stimulus then samples
  task automatic do_trig(input logic [15:0] t, input logic rd);
    trig_valid   = 1'b1;
    trig_time    = t;
    readout_done = rd;
    tick();
    idle_inputs();
  endtask

  task automatic do_readout();
    readout_done = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_start();
    run_start = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    aresetn   = 1'b0;
    holdoff   = 16'd0;
    trig_time = 16'd0;
    idle_inputs();
    repeat (3) tick();
    check_all_zero("reset");
    aresetn = 1'b1;
    tick();
    check("idle_state", 32'(state_o), 32'd0);

    // Start, three back-to-back triggers with holdoff 0
    do_start();
    check("start_run",  32'(running_o), 32'd1);
    check("start_rrst", 32'(run_rst_o), 32'd1);
    check("start_state", 32'(state_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      do_trig(16'h10 + 16'(k), 1'b0);
      check("b2b_valid", 32'(trig_valid_o), 32'd1);
      check("b2b_time",  32'(trig_time_o), 32'h10 + 32'(k));
      check("b2b_evno",  32'(event_no_o), 32'(k));
      check("b2b_outs",  32'(outstanding_o), 32'(k + 1));
    end
    check("b2b_rrst_gone", 32'(run_rst_o), 32'd0);
    tick();
    check("hold_valid_low", 32'(trig_valid_o), 32'd0);
    check("hold_time",      32'(trig_time_o), 32'h12);
    check("hold_evno",      32'(event_no_o), 32'd2);
    check("busy3",          32'(busy_o), 32'd1);
    repeat (3) do_readout();
    check("credits_back", 32'(outstanding_o), 32'd0);
    check("not_busy",     32'(busy_o), 32'd0);
    do_readout();
    check("no_underflow", 32'(outstanding_o), 32'd0);

    // Holdoff 5: triggers every cycle, admitted at k = 0, 6, 12
    holdoff = 16'd5;
    for (int k = 0; k < 13; k++) begin
      do_trig(16'h20 + 16'(k), 1'b0);
      check("holdoff_valid", 32'(trig_valid_o), (k % 6 == 0) ? 32'd1 : 32'd0);
      if (k % 6 == 0) begin
        check("holdoff_evno", 32'(event_no_o), 32'd3 + 32'(k / 6));
        check("holdoff_time", 32'(trig_time_o), 32'h20 + 32'(k));
      end
    end
    check("holdoff_outs", 32'(outstanding_o), 32'd3);
    check("holdoff_drop", 32'(dropped_o), 32'd0);
    holdoff = 16'd0;
    repeat (6) tick();
    repeat (3) do_readout();
    check("holdoff_drain", 32'(outstanding_o), 32'd0);

    // Buffer full: 6 triggers, 4 admitted (ev 6..9), 2 dropped
    for (int k = 0; k < 6; k++) begin
      do_trig(16'h40 + 16'(k), 1'b0);
      check("full_valid", 32'(trig_valid_o), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) check("full_evno", 32'(event_no_o), 32'd6 + 32'(k));
    end
    check("full_outs", 32'(outstanding_o), 32'd4);
    check("full_drop", 32'(dropped_o), 32'd2);
    check("full_evno_hold", 32'(event_no_o), 32'd9);
    // Credit returned in the same cycle as a trigger is not yet usable
    do_trig(16'h50, 1'b1);
    check("sameslot_valid", 32'(trig_valid_o), 32'd0);
    check("sameslot_outs",  32'(outstanding_o), 32'd3);
    check("sameslot_drop",  32'(dropped_o), 32'd3);
    do_trig(16'h51, 1'b0);
    check("freed_valid", 32'(trig_valid_o), 32'd1);
    check("freed_evno",  32'(event_no_o), 32'd10);
    check("freed_outs",  32'(outstanding_o), 32'd4);

    // Admit together with readout at outstanding 2
    repeat (2) do_readout();
    check("pre_sim_outs", 32'(outstanding_o), 32'd2);
    do_trig(16'h60, 1'b1);
    check("sim_valid", 32'(trig_valid_o), 32'd1);
    check("sim_evno",  32'(event_no_o), 32'd11);
    check("sim_outs",  32'(outstanding_o), 32'd2);

    // Stop with a same-cycle trigger, then drain
    run_stop = 1'b1;
    do_trig(16'h70, 1'b0);
    check("stop_run",   32'(running_o), 32'd0);
    check("stop_state", 32'(state_o), 32'd2);
    check("stop_valid", 32'(trig_valid_o), 32'd0);
    check("stop_drop",  32'(dropped_o), 32'd3);
    check("stop_outs",  32'(outstanding_o), 32'd2);
    do_trig(16'h71, 1'b0);
    check("drain_valid", 32'(trig_valid_o), 32'd0);
    check("drain_drop",  32'(dropped_o), 32'd3);
    do_start();
    check("drain_nostart", 32'(state_o), 32'd2);
    check("drain_norrst",  32'(run_rst_o), 32'd0);
    do_readout();
    check("drain_outs1",  32'(outstanding_o), 32'd1);
    do_readout();
    check("drain_outs0",  32'(outstanding_o), 32'd0);
    check("drain_still",  32'(state_o), 32'd2);
    tick();
    check("drain_idle",   32'(state_o), 32'd0);
    check("drain_busy",   32'(busy_o), 32'd0);

    // Start and stop together in IDLE
    run_stop = 1'b1;
    do_start();
    check("ss_state", 32'(state_o), 32'd0);
    check("ss_rrst",  32'(run_rst_o), 32'd0);

    // Restart clears event number and drop count
    do_start();
    check("rs_rrst", 32'(run_rst_o), 32'd1);
    check("rs_drop", 32'(dropped_o), 32'd0);
    do_trig(16'h55, 1'b0);
    check("rs_valid", 32'(trig_valid_o), 32'd1);
    check("rs_evno",  32'(event_no_o), 32'd0);
    check("rs_rrst0", 32'(run_rst_o), 32'd0);
    do_trig(16'h56, 1'b0);
    do_trig(16'h57, 1'b0);
    check("rs_outs", 32'(outstanding_o), 32'd3);
    check("rs_evno2", 32'(event_no_o), 32'd2);

    // Asynchronous reset mid-run: outputs clear without a clock edge
    aresetn = 1'b0;
    #1;
    check_all_zero("async");
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_valid", 32'(trig_valid_o), 32'd0);

    // Event counter wrap after 65536 admitted triggers
    do_start();
    do_trig(16'h0, 1'b0);
    check("wrap_first", 32'(event_no_o), 32'd0);
    for (int i = 1; i < 65536; i++) do_trig(16'(i), 1'b1);
    check("wrap_last",  32'(event_no_o), 32'hFFFF);
    check("wrap_outs1", 32'(outstanding_o), 32'd1);
    do_trig(16'hABCD, 1'b1);
    check("wrap_valid", 32'(trig_valid_o), 32'd1);
    check("wrap_zero",  32'(event_no_o), 32'd0);
    check("wrap_time",  32'(trig_time_o), 32'hABCD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
